// File: rtl/q2_mem_responder.sv
// q2_mem_responder
// Far-end memory / I/O responder for the Q2 CPU bus. It accepts CPU
// write/read strobes, inserts WAIT_CYCLES wait states and returns a
// one-cycle ws ready strobe. Between CPU cycles it services front-panel
// deposit/examine requests against the same storage.

module q2_mem_responder #(
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] dbus_in,
  input  logic                  nwrm,
  input  logic                  rdm,
  input  logic                  io,
  input  logic [DATA_WIDTH-1:0] io_in,
  input  logic                  dep,
  input  logic                  exam,
  input  logic [ADDR_WIDTH-1:0] sw_addr,
  input  logic [DATA_WIDTH-1:0] sw_data,
  output logic [DATA_WIDTH-1:0] dbus_out,
  output logic                  dbus_oe,
  output logic                  ws,
  output logic [DATA_WIDTH-1:0] io_out,
  output logic [DATA_WIDTH-1:0] panel_data,
  output logic                  panel_done
);

  localparam int         DEPTH       = 1 << ADDR_WIDTH;
  localparam logic [3:0] C_WAIT_LOAD = 4'(WAIT_CYCLES);
  localparam bit         C_NO_WAIT   = (WAIT_CYCLES == 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_STROBE = 3'd2,
    S_HOLD   = 3'd3,
    S_PANEL  = 3'd4
  } state_t;

  state_t r_state;
  state_t w_next;

  // Storage: not cleared by reset.
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // Latched CPU request.
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_io;
  logic                  r_wr;
  logic [3:0]            r_cnt;

  // Front-panel synchronizers, edge history and pending flags.
  logic r_dep_s1, r_dep_s2, r_dep_s3;
  logic r_exam_s1, r_exam_s2, r_exam_s3;
  logic r_dep_pend, r_exam_pend;
  logic r_panel_dep;

  // Registered outputs.
  logic [DATA_WIDTH-1:0] r_dbus_out;
  logic                  r_dbus_oe;
  logic                  r_ws;
  logic [DATA_WIDTH-1:0] r_io_out;
  logic [DATA_WIDTH-1:0] r_panel_data;
  logic                  r_panel_done;

  // Combinational helpers.
  logic                  w_req;
  logic                  w_wr;
  logic                  w_dep_rise;
  logic                  w_exam_rise;
  logic [ADDR_WIDTH-1:0] w_rd_addr;
  logic                  w_rd_io;
  logic                  w_rd_is_read;
  logic [DATA_WIDTH-1:0] w_rd_data;
  logic                  w_commit_mem;
  logic                  w_commit_io;
  logic                  w_deposit;

  // A simultaneous write and read request is treated as a write.
  assign w_req       = ~nwrm | rdm;
  assign w_wr        = ~nwrm;
  assign w_dep_rise  = r_dep_s2 & ~r_dep_s3;
  assign w_exam_rise = r_exam_s2 & ~r_exam_s3;

  // With zero wait states the read data is captured straight from IDLE,
  // so the live bus is used there instead of the latched copy.
  assign w_rd_addr    = (r_state == S_IDLE) ? addr : r_addr;
  assign w_rd_io      = (r_state == S_IDLE) ? io   : r_io;
  assign w_rd_is_read = (r_state == S_IDLE) ? ~w_wr : ~r_wr;
  assign w_rd_data    = w_rd_io ? io_in : r_mem[w_rd_addr];

  // Writes commit only on the clock edge that ends STROBE.
  assign w_commit_mem = (r_state == S_STROBE) & r_wr & ~r_io;
  assign w_commit_io  = (r_state == S_STROBE) & r_wr &  r_io;
  assign w_deposit    = (r_state == S_PANEL) & r_panel_dep;

  // State register.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic: CPU beats panel, deposit beats examine.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          if (C_NO_WAIT) begin
            w_next = S_STROBE;
          end else begin
            w_next = S_WAIT;
          end
        end else if (r_dep_pend | r_exam_pend) begin
          w_next = S_PANEL;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_WAIT: begin
        if (r_cnt <= 4'd1) begin
          w_next = S_STROBE;
        end else begin
          w_next = S_WAIT;
        end
      end
      S_STROBE: begin
        w_next = S_HOLD;
      end
      S_HOLD: begin
        if (w_req) begin
          w_next = S_HOLD;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_PANEL: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Latch the CPU request on acceptance and run the wait counter.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_io    <= 1'b0;
      r_wr    <= 1'b0;
      r_cnt   <= 4'd0;
    end else if ((r_state == S_IDLE) && w_req) begin
      r_addr  <= addr;
      r_wdata <= dbus_in;
      r_io    <= io;
      r_wr    <= w_wr;
      r_cnt   <= C_WAIT_LOAD;
    end else if (r_state == S_WAIT) begin
      r_cnt   <= r_cnt - 4'd1;
    end else begin
      r_cnt   <= r_cnt;
    end
  end

  // Two-flop synchronizers plus one history flop for edge detection.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_dep_s1  <= 1'b0;
      r_dep_s2  <= 1'b0;
      r_dep_s3  <= 1'b0;
      r_exam_s1 <= 1'b0;
      r_exam_s2 <= 1'b0;
      r_exam_s3 <= 1'b0;
    end else begin
      r_dep_s1  <= dep;
      r_dep_s2  <= r_dep_s1;
      r_dep_s3  <= r_dep_s2;
      r_exam_s1 <= exam;
      r_exam_s2 <= r_exam_s1;
      r_exam_s3 <= r_exam_s2;
    end
  end

  // Pending flags: set on a detected edge, cleared when serviced; an edge
  // arriving while the flag is already set is dropped.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_dep_pend  <= 1'b0;
      r_exam_pend <= 1'b0;
    end else begin
      if ((r_state == S_PANEL) && r_panel_dep) begin
        r_dep_pend <= 1'b0;
      end else if (w_dep_rise) begin
        r_dep_pend <= 1'b1;
      end else begin
        r_dep_pend <= r_dep_pend;
      end
      if ((r_state == S_PANEL) && !r_panel_dep) begin
        r_exam_pend <= 1'b0;
      end else if (w_exam_rise) begin
        r_exam_pend <= 1'b1;
      end else begin
        r_exam_pend <= r_exam_pend;
      end
    end
  end

  // Remember which panel operation PANEL is servicing.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_panel_dep <= 1'b0;
    end else if ((r_state == S_IDLE) && (w_next == S_PANEL)) begin
      r_panel_dep <= r_dep_pend;
    end else begin
      r_panel_dep <= r_panel_dep;
    end
  end

  // Storage write port: CPU memory write at end of STROBE, or panel deposit.
  always_ff @(posedge clk) begin
    if (nreset && w_commit_mem) begin
      r_mem[r_addr] <= r_wdata;
    end else if (nreset && w_deposit) begin
      r_mem[sw_addr] <= sw_data;
    end
  end

  // Ready strobe: high for exactly the STROBE cycle.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_ws <= 1'b0;
    end else begin
      r_ws <= (w_next == S_STROBE);
    end
  end

  // Read data capture and bus drive enable, held until HOLD releases.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_dbus_out <= '0;
      r_dbus_oe  <= 1'b0;
    end else if (w_next == S_STROBE) begin
      r_dbus_oe <= w_rd_is_read;
      if (w_rd_is_read) begin
        r_dbus_out <= w_rd_data;
      end else begin
        r_dbus_out <= r_dbus_out;
      end
    end else if ((r_state == S_HOLD) && (w_next == S_IDLE)) begin
      r_dbus_oe  <= 1'b0;
    end else begin
      r_dbus_oe  <= r_dbus_oe;
    end
  end

  // Output port latch, written only by a CPU I/O write.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_io_out <= '0;
    end else if (w_commit_io) begin
      r_io_out <= r_wdata;
    end else begin
      r_io_out <= r_io_out;
    end
  end

  // Panel completion pulse and examine result, both valid in PANEL.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_panel_done <= 1'b0;
      r_panel_data <= '0;
    end else begin
      r_panel_done <= (w_next == S_PANEL);
      if ((r_state == S_IDLE) && (w_next == S_PANEL) && !r_dep_pend) begin
        r_panel_data <= r_mem[sw_addr];
      end else begin
        r_panel_data <= r_panel_data;
      end
    end
  end

  assign dbus_out   = r_dbus_out;
  assign dbus_oe    = r_dbus_oe;
  assign ws         = r_ws;
  assign io_out     = r_io_out;
  assign panel_data = r_panel_data;
  assign panel_done = r_panel_done;

endmodule

// File: tb/tb_q2_mem_responder.sv
// Scoreboard bench for q2_mem_responder: expected CPU results are queued
// when a request is driven and compared when ws is seen.

module tb_q2_mem_responder;

  localparam int AW  = 12;
  localparam int DW  = 8;
  localparam int WC  = 2;
  localparam int TMO = 20;

  logic          clk = 1'b0;
  logic          nreset;
  logic [AW-1:0] addr;
  logic [DW-1:0] dbus_in;
  logic          nwrm;
  logic          rdm;
  logic          io;
  logic [DW-1:0] io_in;
  logic          dep;
  logic          exam;
  logic [AW-1:0] sw_addr;
  logic [DW-1:0] sw_data;
  logic [DW-1:0] dbus_out;
  logic          dbus_oe;
  logic          ws;
  logic [DW-1:0] io_out;
  logic [DW-1:0] panel_data;
  logic          panel_done;

  always #5 clk = ~clk;

  q2_mem_responder #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .WAIT_CYCLES(WC)
  ) dut (
    .clk       (clk),
    .nreset    (nreset),
    .addr      (addr),
    .dbus_in   (dbus_in),
    .nwrm      (nwrm),
    .rdm       (rdm),
    .io        (io),
    .io_in     (io_in),
    .dep       (dep),
    .exam      (exam),
    .sw_addr   (sw_addr),
    .sw_data   (sw_data),
    .dbus_out  (dbus_out),
    .dbus_oe   (dbus_oe),
    .ws        (ws),
    .io_out    (io_out),
    .panel_data(panel_data),
    .panel_done(panel_done)
  );

  int n_checks = 0;
  int n_errors = 0;
  int ws_cnt   = 0;
  int done_cnt = 0;

  typedef struct {
    bit            rd;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          sb_q [$];
  logic [DW-1:0] ref_mem [int];

  // Count strobe and panel pulses on every clock.
  always @(posedge clk) begin
    if (ws === 1'b1) ws_cnt <= ws_cnt + 1;
    if (panel_done === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " ws"},         32'(ws),         32'd0);
    check({tag, " dbus_oe"},    32'(dbus_oe),    32'd0);
    check({tag, " dbus_out"},   32'(dbus_out),   32'd0);
    check({tag, " io_out"},     32'(io_out),     32'd0);
    check({tag, " panel_data"}, 32'(panel_data), 32'd0);
    check({tag, " panel_done"}, 32'(panel_done), 32'd0);
  endtask

  // Drive a CPU request and queue what it should produce.
  task automatic cpu_start(input bit wr, input bit rd, input bit isio,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_t e;
    e.rd = rd & ~wr;
    if (e.rd) begin
      e.data = isio ? io_in : ref_mem[int'(a)];
    end else begin
      e.data = d;
      if (!isio) ref_mem[int'(a)] = d;
    end
    sb_q.push_back(e);
    addr    = a;
    dbus_in = d;
    nwrm    = ~wr;
    rdm     = rd;
    io      = isio;
  endtask

  // Wait (bounded) for ws, then pop and compare the scoreboard entry.
  task automatic cpu_wait_ws(input string tag);
    exp_t e;
    int   waited;
    bit   got;
    waited = 0;
    got    = 1'b0;
    e.rd   = 1'b0;
    e.data = '0;
    for (int i = 0; i < TMO; i++) begin
      tick();
      waited++;
      if (ws === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    check({tag, " ws_seen"},    32'(got),    32'd1);
    check({tag, " ws_latency"}, 32'(waited), 32'(WC + 1));
    check({tag, " sb_pending"}, 32'(sb_q.size() > 0), 32'd1);
    if (sb_q.size() > 0) e = sb_q.pop_front();
    if (e.rd) begin
      check({tag, " rdata"},   32'(dbus_out), 32'(e.data));
      check({tag, " oe_read"}, 32'(dbus_oe),  32'd1);
    end else begin
      check({tag, " oe_write"}, 32'(dbus_oe), 32'd0);
    end
    tick();
    check({tag, " ws_one_cycle"}, 32'(ws), 32'd0);
    if (e.rd) check({tag, " oe_hold"}, 32'(dbus_oe), 32'd1);
  endtask

  task automatic cpu_release(input string tag);
    nwrm = 1'b1;
    rdm  = 1'b0;
    io   = 1'b0;
    tick();
    check({tag, " oe_released"}, 32'(dbus_oe), 32'd0);
  endtask

  task automatic cpu_access(input string tag, input bit wr, input bit rd, input bit isio,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
    int ws0;
    ws0 = ws_cnt;
    cpu_start(wr, rd, isio, a, d);
    cpu_wait_ws(tag);
    cpu_release(tag);
    check({tag, " ws_count"}, 32'(ws_cnt - ws0), 32'd1);
  endtask

  // Front-panel operation on an idle bus: done expected 4 clocks after press.
  task automatic panel_req(input string tag, input bit is_dep,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
    int waited;
    bit got;
    waited  = 0;
    got     = 1'b0;
    sw_addr = a;
    sw_data = d;
    if (is_dep) dep = 1'b1;
    else        exam = 1'b1;
    for (int i = 0; i < TMO; i++) begin
      tick();
      waited++;
      if (panel_done === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    check({tag, " done_seen"},    32'(got),    32'd1);
    check({tag, " done_latency"}, 32'(waited), 32'd4);
    check({tag, " no_ws"},        32'(ws),     32'd0);
    if (is_dep) ref_mem[int'(a)] = d;
    else        check({tag, " panel_data"}, 32'(panel_data), 32'(ref_mem[int'(a)]));
    dep  = 1'b0;
    exam = 1'b0;
    tick();
    check({tag, " done_one_cycle"}, 32'(panel_done), 32'd0);
    repeat (3) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  d0;
    int  w0;
    bit  got;
    nreset  = 1'b0;
    addr    = '0;
    dbus_in = '0;
    nwrm    = 1'b1;
    rdm     = 1'b0;
    io      = 1'b0;
    io_in   = '0;
    dep     = 1'b0;
    exam    = 1'b0;
    sw_addr = '0;
    sw_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    nreset = 1'b1;
    tick();

    // Basic memory write then read-back.
    cpu_access("wr123", 1'b1, 1'b0, 1'b0, 12'h123, 8'hA5);
    cpu_access("rd123", 0, 1'b1, 1'b0, 12'h123, 8'h00);

    // I/O write: port updated, memory untouched.
    cpu_access("iowr", 1'b1, 1'b0, 1'b1, 12'h123, 8'h3C);
    check("iowr io_out", 32'(io_out), 32'h3C);
    cpu_access("rd123_after_io", 1'b0, 1'b1, 1'b0, 12'h123, 8'h00);

    // I/O read returns the input port.
    io_in = 8'h77;
    cpu_access("iord", 1'b0, 1'b1, 1'b1, 12'h055, 8'h00);
    io_in = 8'h00;

    // Panel deposit then examine on an idle bus.
    panel_req("dep010",  1'b1, 12'h010, 8'h5A);
    panel_req("exam010", 1'b0, 12'h010, 8'h00);
    check("exam010 io_out_kept", 32'(io_out), 32'h3C);

    // Deposit pressed while a CPU read is held in HOLD.
    d0 = done_cnt;
    cpu_start(1'b0, 1'b1, 1'b0, 12'h123, 8'h00);
    cpu_wait_ws("rd_hold");
    sw_addr = 12'h040;
    sw_data = 8'h99;
    dep = 1'b1;
    repeat (3) tick();
    dep = 1'b0;
    repeat (5) tick();
    check("defer no_done",  32'(done_cnt - d0), 32'd0);
    check("defer rdata",    32'(dbus_out),      32'hA5);
    check("defer oe",       32'(dbus_oe),       32'd1);
    nwrm = 1'b1;
    rdm  = 1'b0;
    got  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (panel_done === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    check("defer done_seen",  32'(got),     32'd1);
    check("defer oe_dropped", 32'(dbus_oe), 32'd0);
    ref_mem[32'h040] = 8'h99;
    repeat (4) tick();
    check("defer done_once", 32'(done_cnt - d0), 32'd1);
    cpu_access("rd040", 1'b0, 1'b1, 1'b0, 12'h040, 8'h00);

    // Write and read asserted together is a write.
    cpu_access("wr_rd_both", 1'b1, 1'b1, 1'b0, 12'h020, 8'h11);
    cpu_access("rd020",      1'b0, 1'b1, 1'b0, 12'h020, 8'h00);

    // Reset during WAIT of a write: nothing committed, no ws.
    cpu_access("wr030_zero", 1'b1, 1'b0, 1'b0, 12'h030, 8'h00);
    w0      = ws_cnt;
    addr    = 12'h030;
    dbus_in = 8'hEE;
    nwrm    = 1'b0;
    rdm     = 1'b0;
    io      = 1'b0;
    tick();
    nreset = 1'b0;
    #1;
    check_reset_outputs("midreset");
    nwrm = 1'b1;
    tick();
    tick();
    nreset = 1'b1;
    repeat (3) tick();
    check("midreset no_ws", 32'(ws_cnt - w0), 32'd0);
    check_reset_outputs("after_reset");
    cpu_access("rd030", 1'b0, 1'b1, 1'b0, 12'h030, 8'h00);
    cpu_access("wr031", 1'b1, 1'b0, 1'b0, 12'h031, 8'hC3);
    cpu_access("rd031", 1'b0, 1'b1, 1'b0, 12'h031, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
